d2d_rx_flit_checker: RTL and testbench
======================================

# d2d_rx_flit_checker

Receive-side link-integrity checker between the framing layer's RX flit output and the protocol core's RX flit input. It verifies CRC-32 and sequence number on every incoming flit and delivers in-order good flits upward. It issues coalesced ACKs, or one NAK per error episode, to the protocol core's replay engine, which is the responder for the TX-side replay buffer. It also drops duplicates and exposes error counters to the CSR block.

## Interface
- FLIT_W, 352, flit width = HEADER_W + PAYLOAD_W + CRC_W
- HEADER_W, 64, header width; header = flit[FLIT_W-1 -: HEADER_W]
- PAYLOAD_W, 256, payload width; payload sits directly below the header
- CRC_W, 32, CRC width; crc = flit[CRC_W-1:0]
- SEQ_W, 8, sequence width; seq = header[SEQ_W-1:0]
- VC_W, 2, VC id width; vc = header[SEQ_W+VC_W-1:SEQ_W]
- ACK_COALESCE, 4, number of good flits per ACK (≥1)
- ACK_TIMEOUT, 64, idle cycles before a partial-batch ACK is flushed (≥2)

Ports:
- clk_i  in  1  clock; single clock domain
- rst_i  in  1  synchronous, active-high reset
- pl_rx_flit_i  in  FLIT_W  flit from framing
- pl_rx_valid_i  in  1  flit valid
- pl_rx_ready_o  out  1  flit accepted when valid & ready
- rx_flit_o  out  FLIT_W  good flit to protocol core
- rx_vc_o  out  VC_W  VC of rx_flit_o
- rx_valid_o  out  1  output valid
- rx_ready_i  in  1  protocol core ready
- ack_valid_o  out  1  ACK/NAK request valid
- ack_is_nak_o  out  1  1 = NAK, 0 = ACK
- ack_seq_o  out  SEQ_W  last good seq (cumulative)
- ack_ready_i  in  1  replay engine accepts the request
- resync_i  in  1  one-cycle pulse; clears sequence state (retrain)
- stat_rx_flits_o  out  32  good flits delivered
- stat_crc_errs_o  out  32  CRC failures
- stat_seq_errs_o  out  32  ahead-of-expected flits
- stat_dups_o  out  32  duplicate flits dropped

## Operation
- CRC: poly 0x04C11DB7, init 0xFFFFFFFF, computed over {header, payload} MSB first, no reflection, no final XOR. Computed combinationally on the input flit.
- Registers:
  - exp_seq (SEQ_W)
  - state ∈ {OK, NAK_WAIT}
  - coal_cnt (0..ACK_COALESCE-1)
  - idle_cnt
  - one-entry output register
  - one-entry ACK register
- pl_rx_ready_o = (!rx_valid_o | rx_ready_i) & (!ack_valid_o | ack_ready_i) & !rst_i.
- Classification of an accepted flit. CRC failure takes precedence over seq checks. diff = (seq − exp_seq) mod 2^SEQ_W.
  - crc_bad: CRC mismatch.
  - good: CRC ok and diff == 0.
  - ahead: CRC ok and 1 ≤ diff < 2^(SEQ_W−1).
  - dup: CRC ok and diff ≥ 2^(SEQ_W−1).
- good, in either state:
  - load the output register; exp_seq++ (wraps modulo 2^SEQ_W); stat_rx_flits++; state → OK.
  - coal_cnt++. When it reaches ACK_COALESCE, emit ACK with seq = this flit's seq and set coal_cnt = 0.
- crc_bad / ahead in OK:
  - drop the flit; emit NAK with seq = exp_seq−1; coal_cnt = 0; state → NAK_WAIT.
  - increment the matching counter.
- crc_bad / ahead in NAK_WAIT: drop the flit and increment the counter; no new NAK is sent.
- dup: drop; stat_dups++; emit ACK with seq = exp_seq−1 (re-ACK); coal_cnt = 0.
- Idle flush:
  - idle_cnt increments each cycle while coal_cnt > 0 and no good flit is accepted, and resets on every good accept.
  - On reaching ACK_TIMEOUT, if the ACK slot is free, emit ACK with seq = exp_seq−1, then set coal_cnt = 0 and idle_cnt = 0.
  - If the slot is busy, idle_cnt holds until the slot is free.
- Simultaneous events:
  - A good flit that completes a batch wins over timer expiry, producing a single ACK.
  - A NAK and an ACK are never produced in the same cycle, because classification is exclusive.
- resync_i:
  - clears exp_seq, coal_cnt, idle_cnt and state (→ OK).
  - drops any pending ACK/NAK (ack_valid_o = 0 next cycle).
  - leaves the output register and counters intact.
  - a flit accepted in the same cycle is classified against the pre-resync state, but its side effects are overridden by the resync.
- Counters wrap at 2^32. Reset clears them; resync_i does not.

## Timing
- Reset: all outputs are 0 and pl_rx_ready_o = 0 while rst_i = 1; exp_seq = 0, state = OK.
- Latency: accept at cycle N → rx_valid_o and/or ack_valid_o asserted at N+1.
- Throughput: 1 flit/cycle when rx_ready_i = 1 and ack_ready_i = 1.
- Output stability: rx_flit_o, rx_vc_o, ack_* are held stable while valid and not ready.
- Dropped flits still require pl_rx_ready_o and consume one cycle.
- Reset asserted mid-transfer discards the output and ACK registers immediately (next edge).

## Test plan
- Eight good flits, seq 0..7, ACK_COALESCE=4, all ready=1 → 8 rx_valid_o beats with 1-cycle latency, ACKs with seq 3 and 7, stat_rx_flits = 8.
- Seq 0,1, then seq 2 with one CRC bit flipped, then seq 3, then seq 2, 3 good → a single NAK with seq 1; flit 3 dropped silently; stat_crc_errs = 1, stat_seq_errs = 1; flits 2 and 3 delivered; state returns to OK.
- Seq 0, 1, 2, then seq 1 again → flit 1 dropped, stat_dups = 1, ACK with seq 2.
- Seq 0..2, then no traffic with ACK_TIMEOUT=64 → ACK with seq 2 on idle cycle 64; no ACK before that.
- 300 good flits with SEQ_W=8 → seq wraps 255→0 with no errors, stat_rx_flits = 300.
- Backpressure: rx_ready_i = 0 for 10 cycles with flits offered → pl_rx_ready_o = 0 after one held flit, rx_flit_o held stable, no loss. Then resync_i pulse during NAK_WAIT → exp_seq = 0, pending NAK dropped, next seq-0 flit delivered.

Source files
------------

// File: rtl/d2d_rx_flit_checker.sv
// Receive-side link-integrity checker: CRC-32 and sequence check on incoming flits,
// in-order delivery of good flits, coalesced ACK / one-shot NAK generation, error counters.
module d2d_rx_flit_checker #(
  parameter int unsigned FLIT_W       = 352,
  parameter int unsigned HEADER_W     = 64,
  parameter int unsigned PAYLOAD_W    = 256,
  parameter int unsigned CRC_W        = 32,
  parameter int unsigned SEQ_W        = 8,
  parameter int unsigned VC_W         = 2,
  parameter int unsigned ACK_COALESCE = 4,
  parameter int unsigned ACK_TIMEOUT  = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [FLIT_W-1:0] pl_rx_flit_i,
  input  logic              pl_rx_valid_i,
  output logic              pl_rx_ready_o,
  output logic [FLIT_W-1:0] rx_flit_o,
  output logic [VC_W-1:0]   rx_vc_o,
  output logic              rx_valid_o,
  input  logic              rx_ready_i,
  output logic              ack_valid_o,
  output logic              ack_is_nak_o,
  output logic [SEQ_W-1:0]  ack_seq_o,
  input  logic              ack_ready_i,
  input  logic              resync_i,
  output logic [31:0]       stat_rx_flits_o,
  output logic [31:0]       stat_crc_errs_o,
  output logic [31:0]       stat_seq_errs_o,
  output logic [31:0]       stat_dups_o
);

  localparam int unsigned DATA_W = HEADER_W + PAYLOAD_W;
  localparam int unsigned COAL_W = (ACK_COALESCE > 1) ? $clog2(ACK_COALESCE) : 1;
  localparam int unsigned IDLE_W = $clog2(ACK_TIMEOUT);
  localparam logic [CRC_W-1:0] CRC_POLY = CRC_W'(32'h04C1_1DB7);

  typedef enum logic {ST_OK, ST_NAK_WAIT} state_t;

  state_t             state_q, state_d;
  logic [SEQ_W-1:0]   exp_seq_q, seq, diff, last_seq, ack_seq_d;
  logic [COAL_W-1:0]  coal_q;
  logic [IDLE_W-1:0]  idle_q;
  logic               crc_ok, ack_free, accept;
  logic               is_good, is_crc_bad, is_ahead, is_bad, is_dup;
  logic               nak_fire, batch_done, idle_run, idle_expire, flush;
  logic               coal_clear, ack_load, ack_nak_d;

  function automatic logic [CRC_W-1:0] crc_calc(input logic [DATA_W-1:0] d);
    logic [CRC_W-1:0] c;
    c = '1;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (c[CRC_W-1] ^ d[DATA_W-1-i]) c = {c[CRC_W-2:0], 1'b0} ^ CRC_POLY;
      else                            c = {c[CRC_W-2:0], 1'b0};
    end
    return c;
  endfunction

  assign seq      = pl_rx_flit_i[FLIT_W-HEADER_W +: SEQ_W];
  assign diff     = seq - exp_seq_q;
  assign last_seq = exp_seq_q - SEQ_W'(1);
  assign crc_ok   = (crc_calc(pl_rx_flit_i[FLIT_W-1 -: DATA_W]) == pl_rx_flit_i[CRC_W-1:0]);

  assign ack_free      = !ack_valid_o || ack_ready_i;
  assign pl_rx_ready_o = (!rx_valid_o || rx_ready_i) && ack_free && !rst_i;
  assign accept        = pl_rx_valid_i && pl_rx_ready_o;

  assign is_crc_bad = accept && !crc_ok;
  assign is_good    = accept && crc_ok && (diff == '0);
  assign is_ahead   = accept && crc_ok && (diff != '0) && !diff[SEQ_W-1];
  assign is_dup     = accept && crc_ok && diff[SEQ_W-1];
  assign is_bad     = is_crc_bad || is_ahead;

  always_ff @(posedge clk_i) begin
    if (rst_i || resync_i) state_q <= ST_OK;
    else                   state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (is_good)     state_d = ST_OK;
    else if (is_bad) state_d = ST_NAK_WAIT;
  end

  // A NAK or re-ACK in the same cycle already acknowledges exp_seq-1, so the flush yields to it.
  always_comb begin
    nak_fire    = is_bad && (state_q == ST_OK);
    batch_done  = is_good && (coal_q == COAL_W'(ACK_COALESCE-1));
    idle_run    = (coal_q != '0) && !is_good;
    idle_expire = idle_run && (idle_q == IDLE_W'(ACK_TIMEOUT-1));
    flush       = idle_expire && ack_free && !nak_fire && !is_dup;
    coal_clear  = nak_fire || is_dup || flush;
    ack_load    = nak_fire || is_dup || batch_done || flush;
    ack_nak_d   = nak_fire;
    ack_seq_d   = batch_done ? seq : last_seq;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || resync_i) begin
      exp_seq_q <= '0;
      coal_q    <= '0;
      idle_q    <= '0;
    end else begin
      if (is_good) exp_seq_q <= exp_seq_q + SEQ_W'(1);
      if (batch_done || coal_clear) coal_q <= '0;
      else if (is_good)             coal_q <= coal_q + COAL_W'(1);
      if (is_good || coal_clear)                  idle_q <= '0;
      else if (idle_run && !(idle_expire && !ack_free)) idle_q <= idle_q + IDLE_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ack_valid_o  <= 1'b0;
      ack_is_nak_o <= 1'b0;
      ack_seq_o    <= '0;
    end else if (resync_i) begin
      ack_valid_o  <= 1'b0;
    end else if (ack_load) begin
      ack_valid_o  <= 1'b1;
      ack_is_nak_o <= ack_nak_d;
      ack_seq_o    <= ack_seq_d;
    end else if (ack_ready_i) begin
      ack_valid_o  <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rx_valid_o <= 1'b0;
      rx_flit_o  <= '0;
      rx_vc_o    <= '0;
    end else if (is_good) begin
      rx_valid_o <= 1'b1;
      rx_flit_o  <= pl_rx_flit_i;
      rx_vc_o    <= pl_rx_flit_i[FLIT_W-HEADER_W+SEQ_W +: VC_W];
    end else if (rx_ready_i) begin
      rx_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      stat_rx_flits_o <= '0;
      stat_crc_errs_o <= '0;
      stat_seq_errs_o <= '0;
      stat_dups_o     <= '0;
    end else begin
      if (is_good)    stat_rx_flits_o <= stat_rx_flits_o + 32'd1;
      if (is_crc_bad) stat_crc_errs_o <= stat_crc_errs_o + 32'd1;
      if (is_ahead)   stat_seq_errs_o <= stat_seq_errs_o + 32'd1;
      if (is_dup)     stat_dups_o     <= stat_dups_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_d2d_rx_flit_checker.sv
// Bench for d2d_rx_flit_checker: directed and random flit streams compared against a
// behavioural link model (CRC by polynomial long division, sequence/ACK bookkeeping).
module tb_d2d_rx_flit_checker;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [351:0] pl_rx_flit_i;
  logic         pl_rx_valid_i;
  logic         pl_rx_ready_o;
  logic [351:0] rx_flit_o;
  logic [1:0]   rx_vc_o;
  logic         rx_valid_o;
  logic         rx_ready_i;
  logic         ack_valid_o;
  logic         ack_is_nak_o;
  logic [7:0]   ack_seq_o;
  logic         ack_ready_i;
  logic         resync_i;
  logic [31:0]  stat_rx_flits_o, stat_crc_errs_o, stat_seq_errs_o, stat_dups_o;

  d2d_rx_flit_checker #(
    .FLIT_W(352), .HEADER_W(64), .PAYLOAD_W(256), .CRC_W(32), .SEQ_W(8), .VC_W(2),
    .ACK_COALESCE(4), .ACK_TIMEOUT(64)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .pl_rx_flit_i(pl_rx_flit_i), .pl_rx_valid_i(pl_rx_valid_i), .pl_rx_ready_o(pl_rx_ready_o),
    .rx_flit_o(rx_flit_o), .rx_vc_o(rx_vc_o), .rx_valid_o(rx_valid_o), .rx_ready_i(rx_ready_i),
    .ack_valid_o(ack_valid_o), .ack_is_nak_o(ack_is_nak_o), .ack_seq_o(ack_seq_o),
    .ack_ready_i(ack_ready_i), .resync_i(resync_i),
    .stat_rx_flits_o(stat_rx_flits_o), .stat_crc_errs_o(stat_crc_errs_o),
    .stat_seq_errs_o(stat_seq_errs_o), .stat_dups_o(stat_dups_o)
  );

  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;

  // Link model
  int          m_exp, m_batch, m_idle;
  bit          m_naking;
  int unsigned m_good, m_crc, m_seqe, m_dup;
  bit          e_rx_v, e_ack_v, e_nak;
  logic [351:0] e_flit;
  logic [1:0]   e_vc;
  logic [7:0]   e_seq;

  localparam logic [32:0] GEN = 33'h1_04C1_1DB7;

  function automatic logic [31:0] ref_crc(input logic [319:0] data);
    logic [351:0] m;
    m = {data, 32'h0};
    m[351 -: 32] = ~m[351 -: 32];
    for (int i = 351; i >= 32; i--)
      if (m[i]) m[i -: 33] = m[i -: 33] ^ GEN;
    return m[31:0];
  endfunction

  function automatic logic [351:0] mk(input int seq, input bit corrupt);
    logic [63:0]  h;
    logic [255:0] p;
    logic [31:0]  c;
    int           b;
    h = {$urandom(), $urandom()};
    h[7:0] = seq[7:0];
    for (int k = 0; k < 8; k++) p[k*32 +: 32] = $urandom();
    c = ref_crc({h, p});
    if (corrupt) begin
      b = $urandom_range(31, 0);
      c[b] = ~c[b];
    end
    return {h, p, c};
  endfunction

  task automatic chk(input string tag, input logic [351:0] obs, input logic [351:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_exp = 0; m_batch = 0; m_idle = 0; m_naking = 0;
    m_good = 0; m_crc = 0; m_seqe = 0; m_dup = 0;
  endtask

  task automatic model(input bit v, input logic [351:0] f);
    int  seq, diff;
    bit  good, bad;
    e_rx_v = 0; e_ack_v = 0; e_nak = 0; e_seq = '0;
    good = 0; bad = 0;
    if (v) begin
      seq  = int'(f[288 +: 8]);
      diff = (seq - m_exp + 256) % 256;
      if (ref_crc(f[351:32]) !== f[31:0]) begin m_crc++; bad = 1; end
      else if (diff == 0) good = 1;
      else if (diff < 128) begin m_seqe++; bad = 1; end
      else begin
        m_dup++;
        e_ack_v = 1; e_seq = 8'((m_exp + 255) % 256);
        m_batch = 0; m_idle = 0;
      end
      if (bad && !m_naking) begin
        e_ack_v = 1; e_nak = 1; e_seq = 8'((m_exp + 255) % 256);
        m_batch = 0; m_idle = 0; m_naking = 1;
      end
      if (good) begin
        e_rx_v = 1; e_flit = f; e_vc = f[296 +: 2];
        m_exp = (m_exp + 1) % 256; m_good++; m_naking = 0; m_idle = 0;
        m_batch++;
        if (m_batch == 4) begin
          e_ack_v = 1; e_seq = 8'(seq); m_batch = 0;
        end
      end
    end
    if (!good && m_batch > 0) begin
      m_idle++;
      if (m_idle == 64) begin
        e_ack_v = 1; e_seq = 8'((m_exp + 255) % 256);
        m_batch = 0; m_idle = 0;
      end
    end
  endtask

  // One cycle with both sinks ready; outputs compared against the model after the edge.
  task automatic step(input bit v, input logic [351:0] f);
    pl_rx_valid_i = v;
    pl_rx_flit_i  = f;
    if (v) begin
      #1;
      chk("pl_ready", pl_rx_ready_o, 1);
    end
    @(posedge clk_i);
    model(v, f);
    #1;
    chk("rx_valid", rx_valid_o, e_rx_v);
    if (e_rx_v) begin
      chk("rx_flit", rx_flit_o, e_flit);
      chk("rx_vc", rx_vc_o, e_vc);
    end
    chk("ack_valid", ack_valid_o, e_ack_v);
    if (e_ack_v) begin
      chk("ack_is_nak", ack_is_nak_o, e_nak);
      chk("ack_seq", ack_seq_o, e_seq);
    end
    pl_rx_valid_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1; pl_rx_valid_i = 1'b0; pl_rx_flit_i = '0;
    resync_i = 1'b0; rx_ready_i = 1'b1; ack_ready_i = 1'b1;
    #1;
    chk("rst_pl_ready", pl_rx_ready_o, 0);
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_rx_valid", rx_valid_o, 0);
    chk("rst_rx_flit", rx_flit_o, 0);
    chk("rst_ack_valid", ack_valid_o, 0);
    chk("rst_stat_rx", stat_rx_flits_o, 0);
    chk("rst_stat_crc", stat_crc_errs_o, 0);
    chk("rst_stat_dup", stat_dups_o, 0);
    rst_i = 1'b0;
    model_reset();
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_stat_rx"},  stat_rx_flits_o, m_good);
    chk({tag, "_stat_crc"}, stat_crc_errs_o, m_crc);
    chk({tag, "_stat_seq"}, stat_seq_errs_o, m_seqe);
    chk({tag, "_stat_dup"}, stat_dups_o, m_dup);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [351:0] f0, f1;
    int r, first;

    // Eight in-order flits: ACKs at seq 3 and 7
    do_reset();
    for (int s = 0; s < 8; s++) step(1, mk(s, 0));
    chk_stats("burst8");
    chk("burst8_rx_count", stat_rx_flits_o, 8);

    // CRC error episode: single NAK with seq 1, ahead flit dropped silently
    do_reset();
    step(1, mk(0, 0)); step(1, mk(1, 0));
    step(1, mk(2, 1)); step(1, mk(3, 0));
    step(1, mk(2, 0)); step(1, mk(3, 0));
    chk_stats("nak");
    chk("nak_crc_count", stat_crc_errs_o, 1);
    chk("nak_seq_count", stat_seq_errs_o, 1);
    step(1, mk(9, 0));  // fresh error after recovery must NAK again

    // Duplicate triggers re-ACK of seq 2
    do_reset();
    for (int s = 0; s < 3; s++) step(1, mk(s, 0));
    step(1, mk(1, 0));
    chk("dup_count", stat_dups_o, 1);

    // Idle flush after exactly 64 idle cycles
    do_reset();
    for (int s = 0; s < 3; s++) step(1, mk(s, 0));
    first = 0;
    for (int i = 1; i <= 70; i++) begin
      step(0, '0);
      if (ack_valid_o && first == 0) first = i;
    end
    chk("idle_flush_cycle", first, 64);

    // Sequence wrap over 300 flits
    do_reset();
    for (int s = 0; s < 300; s++) step(1, mk(s % 256, 0));
    chk_stats("wrap");
    chk("wrap_rx_count", stat_rx_flits_o, 300);

    // Random mix of good / corrupted / ahead / duplicate / idle
    do_reset();
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(99, 0);
      if (r < 50)      step(1, mk(m_exp, 0));
      else if (r < 60) step(1, mk(m_exp, 1));
      else if (r < 70) step(1, mk((m_exp + 1 + $urandom_range(126, 0)) % 256, 0));
      else if (r < 80) step(1, mk((m_exp + 255 - $urandom_range(127, 0)) % 256, 0));
      else             step(0, '0);
    end
    chk_stats("rand");

    // Backpressure: one flit held, link stalled, no loss
    do_reset();
    rx_ready_i = 1'b0;
    f0 = mk(0, 0); f1 = mk(1, 0);
    pl_rx_valid_i = 1'b1; pl_rx_flit_i = f0;
    #1 chk("bp_ready_first", pl_rx_ready_o, 1);
    @(posedge clk_i); #1;
    chk("bp_rx_valid", rx_valid_o, 1);
    chk("bp_rx_flit0", rx_flit_o, f0);
    pl_rx_flit_i = f1;
    for (int i = 0; i < 10; i++) begin
      chk("bp_ready_stall", pl_rx_ready_o, 0);
      @(posedge clk_i); #1;
      chk("bp_hold_flit", rx_flit_o, f0);
      chk("bp_hold_valid", rx_valid_o, 1);
    end
    rx_ready_i = 1'b1;
    #1 chk("bp_ready_resume", pl_rx_ready_o, 1);
    @(posedge clk_i); #1;
    chk("bp_rx_flit1", rx_flit_o, f1);
    pl_rx_valid_i = 1'b0;
    @(posedge clk_i); #1;
    chk("bp_drain", rx_valid_o, 0);

    // NAK pending under ack backpressure, then resync drops it
    ack_ready_i = 1'b0;
    pl_rx_valid_i = 1'b1; pl_rx_flit_i = mk(5, 0);
    @(posedge clk_i); #1;
    pl_rx_valid_i = 1'b0;
    chk("rs_nak_valid", ack_valid_o, 1);
    chk("rs_nak_flag", ack_is_nak_o, 1);
    chk("rs_nak_seq", ack_seq_o, 1);
    repeat (3) @(posedge clk_i);
    #1 chk("rs_nak_held", ack_valid_o, 1);
    chk("rs_ready_blocked", pl_rx_ready_o, 0);
    resync_i = 1'b1;
    @(posedge clk_i); #1;
    resync_i = 1'b0;
    chk("rs_ack_dropped", ack_valid_o, 0);
    f0 = mk(0, 0);
    pl_rx_valid_i = 1'b1; pl_rx_flit_i = f0;
    @(posedge clk_i); #1;
    pl_rx_valid_i = 1'b0;
    chk("rs_seq0_valid", rx_valid_o, 1);
    chk("rs_seq0_flit", rx_flit_o, f0);
    chk("rs_no_ack", ack_valid_o, 0);
    chk("rs_stat_rx", stat_rx_flits_o, 3);
    chk("rs_stat_seq", stat_seq_errs_o, 1);

    // Reset mid-transfer discards the held output
    rx_ready_i = 1'b0;
    pl_rx_valid_i = 1'b1; pl_rx_flit_i = mk(1, 0);
    @(posedge clk_i); #1;
    pl_rx_valid_i = 1'b0;
    chk("mr_held", rx_valid_o, 1);
    rst_i = 1'b1;
    #1 chk("mr_ready_low", pl_rx_ready_o, 0);
    @(posedge clk_i); #1;
    chk("mr_rx_valid", rx_valid_o, 0);
    chk("mr_stat_rx", stat_rx_flits_o, 0);
    rst_i = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
